// File: rtl/aux_memory_writer.sv
// Purpose: host write requests -> small FIFO -> tri_port_memory write port, plus whole-memory clear.
// Latency: 2 clocks from request acceptance to memory_wr_out; a clear issues 2**AUX_ADDRESS_WIDTH writes.
// Backpressure: req_ready_out drops when the FIFO is full. Optional macro VBLANK_GATE_EN limits writes to blanking.

// Request FIFO: circular buffer with registered occupancy and ready.
module aux_memory_writer_fifo #(
  parameter int WIDTH      = 21,
  parameter int DEPTH      = 4,
  parameter int DEPTH_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_data,
  output logic [DEPTH_BITS:0]   count,
  output logic [DEPTH_BITS:0]   next_count,
  output logic                  ready
);

  logic [WIDTH-1:0]      store [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  // ready already reflects a full FIFO, so a push while full is simply dropped
  assign push_ok   = push && ready;
  assign pop_ok    = pop && (count != '0);
  assign head_data = store[rd_ptr];

  // Occupancy after this edge; simultaneous push and pop cancel out
  always_comb begin
    next_count = count;
    case ({push_ok, pop_ok})
      2'b10:   next_count = count + 1'b1;
      2'b01:   next_count = count - 1'b1;
      default: next_count = count;
    endcase
  end

  // Pointer, occupancy and ready registers; DEPTH is a power of 2 so full is the MSB of count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= next_count;
      ready <= ~next_count[DEPTH_BITS];
    end
  end

  // Payload storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok) store[wr_ptr] <= push_data;
  end

endmodule

module aux_memory_writer #(
  parameter int DATA_WIDTH        = 16,
  parameter int AUX_ADDRESS_WIDTH = 5,
  parameter int FIFO_DEPTH        = 4,
  parameter int FIFO_DEPTH_BITS   = 2
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic                         req_valid_in,
  input  logic [AUX_ADDRESS_WIDTH-1:0] req_address_in,
  input  logic [DATA_WIDTH-1:0]        req_data_in,
  output logic                         req_ready_out,
  input  logic                         clear_in,
  input  logic [DATA_WIDTH-1:0]        clear_data_in,
  input  logic                         display_on_in,
  output logic                         memory_wr_out,
  output logic [AUX_ADDRESS_WIDTH-1:0] write_address_out,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         busy_out,
  output logic [FIFO_DEPTH_BITS:0]     fifo_count_out
);

  typedef struct packed {
    logic [AUX_ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]        data;
  } req_t;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                       state_q, state_nxt;
  logic                         clr_pend_q, clr_pend_nxt;
  logic [DATA_WIDTH-1:0]        clr_val_q, clr_val_nxt;
  // One extra bit so the count reaching 2**AUX_ADDRESS_WIDTH marks the end unambiguously
  logic [AUX_ADDRESS_WIDTH:0]   clr_cnt_q, clr_cnt_nxt;
  logic                         wr_q, wr_nxt;
  logic [AUX_ADDRESS_WIDTH-1:0] addr_q, addr_nxt;
  logic [DATA_WIDTH-1:0]        data_q, data_nxt;
  logic                         busy_q;
  logic                         pop;
  logic                         write_ok;
  req_t                         req_in;
  req_t                         head;
  logic [FIFO_DEPTH_BITS:0]     count;
  logic [FIFO_DEPTH_BITS:0]     next_count;

`ifdef VBLANK_GATE_EN
  logic disp_q;

  // Registered display_on; writes only happen while the frame_generator is in blanking
  always_ff @(posedge clock_in) begin
    if (reset_in) disp_q <= 1'b0;
    else          disp_q <= display_on_in;
  end

  assign write_ok = ~disp_q;
`else
  logic unused_display_on;
  assign unused_display_on = display_on_in;
  assign write_ok          = 1'b1;
`endif

  assign req_in.addr = req_address_in;
  assign req_in.data = req_data_in;

  aux_memory_writer_fifo #(
    .WIDTH      ($bits(req_t)),
    .DEPTH      (FIFO_DEPTH),
    .DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_fifo (
    .clk        (clock_in),
    .rst        (reset_in),
    .push       (req_valid_in),
    .push_data  (req_in),
    .pop        (pop),
    .head_data  (head),
    .count      (count),
    .next_count (next_count),
    .ready      (req_ready_out)
  );

  // Next state and next registered write-port values; clear beats the drain once latched
  always_comb begin
    state_nxt    = state_q;
    clr_pend_nxt = clr_pend_q;
    clr_val_nxt  = clr_val_q;
    clr_cnt_nxt  = clr_cnt_q;
    wr_nxt       = 1'b0;
    addr_nxt     = addr_q;
    data_nxt     = data_q;
    pop          = 1'b0;

    // A clear is only captured in IDLE with none pending, so pulses during a clear are ignored
    if ((state_q == IDLE) && !clr_pend_q && clear_in) begin
      clr_pend_nxt = 1'b1;
      clr_val_nxt  = clear_data_in;
    end

    case (state_q)
      IDLE: begin
        if (clr_pend_q) begin
          state_nxt    = CLEAR;
          clr_pend_nxt = 1'b0;
          clr_cnt_nxt  = '0;
        end else if ((count != '0) && write_ok) begin
          pop      = 1'b1;
          wr_nxt   = 1'b1;
          addr_nxt = head.addr;
          data_nxt = head.data;
        end
      end
      CLEAR: begin
        if (write_ok) begin
          wr_nxt      = 1'b1;
          addr_nxt    = clr_cnt_q[AUX_ADDRESS_WIDTH-1:0];
          data_nxt    = clr_val_q;
          clr_cnt_nxt = clr_cnt_q + 1'b1;
          if (clr_cnt_nxt[AUX_ADDRESS_WIDTH]) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset abandons any clear or drain in progress
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q    <= IDLE;
      clr_pend_q <= 1'b0;
      clr_val_q  <= '0;
      clr_cnt_q  <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      clr_pend_q <= clr_pend_nxt;
      clr_val_q  <= clr_val_nxt;
      clr_cnt_q  <= clr_cnt_nxt;
      wr_q       <= wr_nxt;
      addr_q     <= addr_nxt;
      data_q     <= data_nxt;
      busy_q     <= (state_nxt == CLEAR) || clr_pend_nxt || (next_count != '0) || wr_nxt;
    end
  end

  assign memory_wr_out     = wr_q;
  assign write_address_out = addr_q;
  assign data_out          = data_q;
  assign busy_out          = busy_q;
  assign fifo_count_out    = count;

endmodule

// File: tb/tb_aux_memory_writer.sv
// Bench for aux_memory_writer: directed steps, write scoreboard fed at stimulus time.
// Latency: checks the 2-clock request-to-write path and 32-cycle clears.
// Backpressure: fills the FIFO behind a clear (and behind display_on when gated).
module tb_aux_memory_writer;

  localparam int DW  = 16;
  localparam int AW  = 5;
  localparam int FD  = 4;
  localparam int FDB = 2;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          req_ready_out;
  logic          clear;
  logic [DW-1:0] clear_data;
  logic          display_on;
  logic          memory_wr_out;
  logic [AW-1:0] write_address_out;
  logic [DW-1:0] data_out;
  logic          busy_out;
  logic [FDB:0]  fifo_count_out;

  int            total;
  int            bad;
  int            wr_seen;
  int            abcd_cnt;
  logic [31:0]   exp_q[$];
  logic [DW-1:0] mem [2**AW];

  aux_memory_writer #(
    .DATA_WIDTH        (DW),
    .AUX_ADDRESS_WIDTH (AW),
    .FIFO_DEPTH        (FD),
    .FIFO_DEPTH_BITS   (FDB)
  ) dut (
    .clock_in          (clk),
    .reset_in          (reset),
    .req_valid_in      (req_valid),
    .req_address_in    (req_addr),
    .req_data_in       (req_data),
    .req_ready_out     (req_ready_out),
    .clear_in          (clear),
    .clear_data_in     (clear_data),
    .display_on_in     (display_on),
    .memory_wr_out     (memory_wr_out),
    .write_address_out (write_address_out),
    .data_out          (data_out),
    .busy_out          (busy_out),
    .fifo_count_out    (fifo_count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mkw(input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {11'b0, a, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold a request until accepted (bounded); the expected write is queued on acceptance
  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, output int cycles);
    logic acc;
    acc = 1'b0;
    cycles = 0;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    while (!acc && cycles < 300) begin
      acc = req_ready_out;
      tick();
      cycles++;
    end
    req_valid = 1'b0;
    if (acc) exp_q.push_back(mkw(a, d));
    chk("accept", 32'(acc), 1);
  endtask

  // One-cycle clear pulse; n_exp words of the fill value are expected to follow
  task automatic pulse_clear(input logic [DW-1:0] v, input int n_exp);
    clear      = 1'b1;
    clear_data = v;
    for (int i = 0; i < n_exp; i++) exp_q.push_back(mkw(AW'(i), v));
    tick();
    clear = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic done;
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      tick();
      if (!busy_out && !memory_wr_out) done = 1'b1;
    end
    chk(tag, 32'(done), 1);
  endtask

  initial begin
    int cyc;
    int slow;
    int errs;
    int seen_before;
    logic found;

    total = 0; bad = 0; wr_seen = 0; abcd_cnt = 0;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0;
    clear = 1'b0; clear_data = '0; display_on = 1'b0;
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;

    // Write-port monitor: every write must match the head of the scoreboard
    fork
      forever begin
        logic [31:0] e;
        @(negedge clk);
        if (memory_wr_out === 1'b1) begin
          wr_seen++;
          if (data_out == 16'hABCD) abcd_cnt++;
          mem[write_address_out] = data_out;
          if (exp_q.size() == 0) chk("unexpected_write", mkw(write_address_out, data_out), 32'hFFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            chk("write", mkw(write_address_out, data_out), e);
          end
        end
      end
    join_none

    // Reset state
    repeat (3) tick();
    chk("rst_wr",    32'(memory_wr_out), 0);
    chk("rst_addr",  32'(write_address_out), 0);
    chk("rst_data",  32'(data_out), 0);
    chk("rst_busy",  32'(busy_out), 0);
    chk("rst_count", 32'(fifo_count_out), 0);
    chk("rst_ready", 32'(req_ready_out), 1);
    reset = 1'b0;
    tick();

    // Single request: write appears 2 clocks after acceptance, busy falls after it
    send(5'd5, 16'h0014, cyc);
    chk("single_count", 32'(fifo_count_out), 1);
    chk("single_wr0",   32'(memory_wr_out), 0);
    chk("single_busy0", 32'(busy_out), 1);
    tick();
    chk("single_wr1",   32'(memory_wr_out), 1);
    chk("single_addr",  32'(write_address_out), 5);
    chk("single_data",  32'(data_out), 32'h0014);
    tick();
    chk("single_wr2",   32'(memory_wr_out), 0);
    chk("single_busy2", 32'(busy_out), 0);

    // Burst of 30 with valid held: drain keeps pace, ready never drops
    slow = 0;
    for (int i = 0; i < 30; i++) begin
      send(AW'(i), DW'(16'h000F + i), cyc);
      if (cyc != 1) slow++;
    end
    chk("burst_stalls", 32'(slow), 0);
    wait_idle("burst_idle");
    for (int i = 0; i < 30; i++) chk("burst_mem", 32'(mem[i]), 32'h000F + i);

    // FIFO fills behind a clear: 4 accepted, 5th waits, then order is preserved
    pulse_clear(16'h0077, 32);
    for (int i = 0; i < 4; i++) send(AW'(20 + i), DW'(16'h2000 + i), cyc);
    req_valid = 1'b1; req_addr = 5'd24; req_data = 16'h2004;
    chk("full_count", 32'(fifo_count_out), 4);
    chk("full_ready", 32'(req_ready_out), 0);
    send(5'd24, 16'h2004, cyc);
    chk("full_5th_waited", 32'(cyc > 20), 1);
    wait_idle("full_idle");

`ifdef VBLANK_GATE_EN
    // Display active stalls the drain; blanking releases it in order
    display_on = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 4; i++) send(AW'(10 + i), DW'(16'h3000 + i), cyc);
    chk("vb_count", 32'(fifo_count_out), 4);
    chk("vb_ready", 32'(req_ready_out), 0);
    chk("vb_wr",    32'(memory_wr_out), 0);
    req_valid = 1'b1; req_addr = 5'd14; req_data = 16'h3004;
    tick();
    chk("vb_hold_count", 32'(fifo_count_out), 4);
    display_on = 1'b0;
    send(5'd14, 16'h3004, cyc);
    wait_idle("vb_idle");
`endif

    // Clear with a request during it and a second ignored pulse
    abcd_cnt = 0;
    pulse_clear(16'hABCD, 32);
    send(5'd3, 16'h1111, cyc);
    repeat (8) tick();
    chk("in_clear_busy", 32'(busy_out), 1);
    pulse_clear(16'h5555, 0);
    wait_idle("clear_idle");
    chk("clear_writes", 32'(abcd_cnt), 32);
    chk("clear_mem3", 32'(mem[3]), 32'h1111);
    errs = 0;
    for (int i = 0; i < 2**AW; i++) if (i != 3 && mem[i] != 16'hABCD) errs++;
    chk("clear_mem_rest", 32'(errs), 0);

    // Reset at clear address 10 with two FIFO entries: everything stops
    pulse_clear(16'h0BAD, 11);
    send(5'd7, 16'h7777, cyc);
    send(5'd8, 16'h8888, cyc);
    exp_q.pop_back();
    exp_q.pop_back();
    chk("pre_rst_count", 32'(fifo_count_out), 2);
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      if (memory_wr_out && write_address_out == 5'd10) found = 1'b1;
      else tick();
    end
    chk("reached_addr10", 32'(found), 1);
    reset = 1'b1;
    tick();
    chk("abort_wr",    32'(memory_wr_out), 0);
    chk("abort_count", 32'(fifo_count_out), 0);
    chk("abort_busy",  32'(busy_out), 0);
    chk("abort_ready", 32'(req_ready_out), 1);
    tick();
    reset = 1'b0;
    seen_before = wr_seen;
    repeat (50) tick();
    chk("post_rst_writes", 32'(wr_seen - seen_before), 0);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aux_memory_writer.md
Name: aux_memory_writer

Overview:
Write-side front end for the tri_port_memory auxiliary memory. The frame_generator reads that memory on its address_1 port.
- Accepts CPU/host write requests over a valid/ready handshake.
- Buffers the requests in a small FIFO.
- Drains the FIFO into the memory write port (data_in, write_address_in, memory_wr_in), one word per clock.
- A clear command fills every memory location with a given value.

Parameters:
DATA_WIDTH, 16, width of a memory word
AUX_ADDRESS_WIDTH, 5, memory address width; memory holds 2**AUX_ADDRESS_WIDTH words
FIFO_DEPTH, 4, request FIFO entries; must be a power of 2, at least 2
FIFO_DEPTH_BITS, 2, log2(FIFO_DEPTH)

Ports:
clock_in  input  1  write clock; same clock as the memory write_clock_in
reset_in  input  1  synchronous, active-high reset
req_valid_in  input  1  host write request valid
req_address_in  input  AUX_ADDRESS_WIDTH  target address
req_data_in  input  DATA_WIDTH  write data
req_ready_out  output  1  FIFO can accept a request
clear_in  input  1  one-cycle pulse: start a clear of the whole memory
clear_data_in  input  DATA_WIDTH  fill value, sampled on the clear_in cycle
display_on_in  input  1  vga_sync display_on; used only with VBLANK_GATE_EN
memory_wr_out  output  1  to memory_wr_in
write_address_out  output  AUX_ADDRESS_WIDTH  to write_address_in
data_out  output  DATA_WIDTH  to data_in
busy_out  output  1  high while clearing or while the FIFO is non-empty
fifo_count_out  output  FIFO_DEPTH_BITS+1  FIFO occupancy

Behaviour:
- All outputs are registered.
- Reset: memory_wr_out=0, write_address_out=0, data_out=0, busy_out=0, fifo_count_out=0, req_ready_out=1. FIFO pointers are 0 and the state is IDLE.
- Reset mid-clear or mid-drain aborts immediately. FIFO contents are discarded and no further write is issued.
- Handshake:
  - A request is accepted on a rising edge where req_valid_in && req_ready_out.
  - req_ready_out = (count < FIFO_DEPTH), computed from registered state.
  - When full, the host must hold valid, address and data stable until accepted.
- FIFO:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH.
  - A push and a pop in the same cycle leave the count unchanged.
  - A push when full is ignored (ready is already low).
- States:
  - IDLE: if the clear is latched, go to CLEAR. Otherwise, if the FIFO is non-empty, pop one entry. The next cycle drives memory_wr_out=1 with that entry's address and data.
  - The drain stays in IDLE: back-to-back entries give one write per cycle.
  - If the FIFO is empty, memory_wr_out=0; address and data hold their last values.
  - CLEAR: iterate an address counter 0 .. 2**AUX_ADDRESS_WIDTH-1. Each cycle drive memory_wr_out=1, write_address_out=counter, data_out=latched clear value. After the last address, return to IDLE; the next cycle has memory_wr_out=0 unless the FIFO drains.
  - A clear of 32 words takes exactly 32 write cycles.
  - Address counter width is AUX_ADDRESS_WIDTH+1 so the terminal count is detected without wrap ambiguity.
- Latency: a request accepted at edge N, with the FIFO empty and state IDLE, produces memory_wr_out=1 in the cycle after edge N+1, i.e. 2 clocks from acceptance.
- clear_in during CLEAR is ignored (no restart).
- clear_in in IDLE:
  - It has priority over the FIFO drain.
  - A write popped on the same edge still completes its single write cycle; the clear starts on the next cycle.
  - Requests continue to be accepted into the FIFO during CLEAR and drain after it, in FIFO order, so host writes after a clear win.
- busy_out = (state==CLEAR) || (count!=0) || memory_wr_out.

Optional Feature:
VBLANK_GATE_EN:
- Defined: FIFO pops and CLEAR write cycles occur only in cycles where display_on_in==0 (registered one stage). While display_on_in==1, memory_wr_out=0, the clear counter holds, and the FIFO keeps accepting until full. This avoids tearing on the frame_generator read port.
- Undefined: display_on_in is ignored and writes proceed unconditionally.

Test Plan:
- Reset, then a single request addr=5, data=0x0014 -> memory_wr_out=1, write_address_out=5, data_out=0x0014 exactly 2 clocks after acceptance; busy_out falls the next cycle.
- Burst of 30 requests with valid held high (addr=i, data=0x000F+i), memory write port observed -> req_ready_out never drops (drain keeps pace). Memory reads back 0x000F+i at address i for i=0..29.
- Stall the drain by holding reset-free backpressure (VBLANK_GATE_EN, display_on_in=1), push 5 requests -> 4 accepted, req_ready_out=0, fifo_count_out=4. On display_on_in=0 the 4 entries write in order, then the 5th is accepted.
- clear_in with clear_data_in=0xABCD, then a request addr=3, data=0x1111 during CLEAR -> 32 consecutive writes 0..31 of 0xABCD, then addr 3 = 0x1111; final memory[3]=0x1111, all others 0xABCD.
- Second clear_in pulse mid-clear -> ignored; total clear write cycles = 32.
- reset_in asserted at clear address 10 with 2 FIFO entries -> memory_wr_out=0 the next cycle and fifo_count_out=0; no further writes.
